// File: rtl/enemy_sprite_sequencer.sv
// Enemy sprite animation FSM and pixel-to-ROM address pipeline.
// Frame-packed sprite sheet; 1-cycle ROM latency, mirrored on facing_left.
module enemy_sprite_sequencer #(
  parameter int SPR_W       = 40,
  parameter int SPR_H       = 66,
  parameter int RUN_FRAMES  = 6,
  parameter int DIE_FRAMES  = 3,
  parameter int FRAME_TICKS = 6,
  parameter int AIM_STEPS   = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              facing_left,
  input  logic              alive,
  input  logic              shoot_req,
  input  logic              fire_ready,
  output logic              fire_valid,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_on,
  output logic [2:0]        anim_state,
  output logic [2:0]        frame_idx
);

  typedef enum logic [2:0] {
    DEAD = 3'd0,
    RUN  = 3'd1,
    AIM  = 3'd2,
    FIRE = 3'd3,
    DIE  = 3'd4
  } state_t;

  localparam logic [9:0] W10 = 10'(SPR_W);
  localparam logic [9:0] H10 = 10'(SPR_H);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [2:0] TICK_LAST = 3'(FRAME_TICKS - 1);
  localparam logic [2:0] RUN_LAST = 3'(RUN_FRAMES - 1);
  localparam logic [2:0] DIE_LAST = 3'(DIE_FRAMES - 1);
  localparam logic [2:0] AIM_LAST = 3'(AIM_STEPS - 1);

  state_t state_q, state_d;
  logic [2:0] fidx_q, fidx_d;
  logic [2:0] tick_q, tick_d;
  logic [2:0] steps_q, steps_d;
  logic fv_q, fv_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic box_q, on_q;

  logic step;
  logic hit;
  logic [3:0] slot;
  logic [9:0] lx, ly, col;
  logic in_box;

  always_comb begin
    step = frame_start && (tick_q == TICK_LAST);
    hit = fv_q && fire_ready;
    tick_d = tick_q;
    if (frame_start) tick_d = step ? 3'd0 : tick_q + 3'd1;
    state_d = state_q;
    fidx_d = fidx_q;
    steps_d = steps_q;
    fv_d = fv_q;
    // Losing alive pre-empts every other transition, even mid-handshake.
    if (!alive && (state_q == RUN || state_q == AIM ||
                   state_q == FIRE)) begin
      state_d = DIE;
      fidx_d = 3'd0;
      fv_d = 1'b0;
    end else begin
      unique case (state_q)
        DEAD: if (frame_start && alive) begin
          state_d = RUN;
          fidx_d = 3'd0;
          tick_d = 3'd0;
        end
        RUN: if (step) begin
          if (shoot_req) begin
            state_d = AIM;
            fidx_d = 3'd0;
            steps_d = 3'd0;
          end else begin
            fidx_d = (fidx_q == RUN_LAST) ? 3'd0 : fidx_q + 3'd1;
          end
        end
        AIM: if (step) begin
          steps_d = steps_q + 3'd1;
          if (steps_q == AIM_LAST) begin
            state_d = FIRE;
            fv_d = 1'b1;
          end
        end
        FIRE: begin
          fv_d = 1'b1;
          if (hit) begin
            fv_d = 1'b0;
            state_d = RUN;
            fidx_d = 3'd0;
          end
        end
        DIE: if (step) begin
          if (fidx_q == DIE_LAST) begin
            state_d = DEAD;
            fidx_d = 3'd0;
          end else begin
            fidx_d = fidx_q + 3'd1;
          end
        end
        default: state_d = DEAD;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      RUN:     slot = {1'b0, fidx_q};
      AIM:     slot = 4'(RUN_FRAMES);
      FIRE:    slot = 4'(RUN_FRAMES + 1);
      DIE:     slot = 4'(RUN_FRAMES + 2) + {1'b0, fidx_q};
      default: slot = 4'd0;
    endcase
    // Latch only at vblank so a frame never tears mid-scan.
    base_d = frame_start ? ADDR_W'(slot) * FRAME_SZ : base_q;
  end

  always_comb begin
    lx = DrawX - pos_x;
    ly = DrawY - pos_y;
    in_box = (DrawX >= pos_x) && (lx < W10) &&
             (DrawY >= pos_y) && (ly < H10) &&
             (state_q != DEAD);
    col = facing_left ? (W10 - 10'd1 - lx) : lx;
    addr_d = '0;
    if (in_box)
      addr_d = base_q + ADDR_W'(ly) * W_A + ADDR_W'(col);
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= DEAD;
      fidx_q <= 3'd0;
      tick_q <= 3'd0;
      steps_q <= 3'd0;
      fv_q <= 1'b0;
      base_q <= '0;
      addr_q <= '0;
      box_q <= 1'b0;
      on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fidx_q <= fidx_d;
      tick_q <= tick_d;
      steps_q <= steps_d;
      fv_q <= fv_d;
      base_q <= base_d;
      addr_q <= addr_d;
      box_q <= in_box;
      on_q <= box_q;
    end
  end

  assign fire_valid = fv_q;
  assign rom_address = addr_q;
  assign sprite_on = on_q;
  assign anim_state = state_q;
  assign frame_idx = fidx_q;

endmodule
